// File: rtl/pcileech_sysctl_pkg.sv
// Shared types for the board system-control block: reset sequencer states
// and per-LED drive modes.
package pcileech_sysctl_pkg;

    typedef enum logic [1:0] {
        ST_POR   = 2'd0,
        ST_STAGE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } sysctl_state_t;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_ACT   = 2'd3
    } led_mode_t;

endpackage

// File: rtl/pcileech_debounce.sv
// Single-button debouncer: two-flop synchroniser followed by a stability
// counter that only accepts a new level after DEBOUNCE_CYCLES of agreement.
module pcileech_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/pcileech_sysctl.sv
// Board system control: 64-bit tick count, debounced buttons, staged reset
// sequencer with button-forced reset, and per-LED mode/stretch/inversion.
module pcileech_sysctl
    import pcileech_sysctl_pkg::*;
#(
    parameter int                 NUM_BTN         = 2,
    parameter int                 NUM_LED         = 3,
    parameter int                 NUM_RST         = 3,
    parameter int                 POR_CYCLES      = 64,
    parameter int                 STAGE_GAP       = 16,
    parameter int                 DEBOUNCE_CYCLES = 1000000,
    parameter logic [NUM_BTN-1:0] BTN_RST_MASK    = 'b10,
    parameter int                 BLINK_BIT       = 26,
    parameter int                 STRETCH_CYCLES  = 5000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BTN-1:0]   btn_raw,
    output logic [NUM_BTN-1:0]   btn_db,
    output logic [63:0]          tickcount64,
    output logic [NUM_RST-1:0]   rst_stage,
    input  logic [2*NUM_LED-1:0] led_mode,
    input  logic [NUM_LED-1:0]   led_act,
    input  logic [NUM_LED-1:0]   led_inv,
    output logic [NUM_LED-1:0]   led
);

    localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam int STR_W = $clog2(STRETCH_CYCLES + 1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            pcileech_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_raw(btn_raw[gi]),
                .btn_db (btn_db[gi])
            );
        end
    endgenerate

    logic [63:0]        tick_q;
    sysctl_state_t      state_q, state_d;
    logic [POR_W-1:0]   por_cnt_q, por_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_RST-1:0] rst_stage_q, rst_stage_d;
    logic               force_rst;

    assign force_rst = |(btn_db & BTN_RST_MASK);

    // A forced reset takes priority over any release due on the same edge.
    always_comb begin
        state_d     = state_q;
        por_cnt_d   = por_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        idx_d       = idx_q;
        rst_stage_d = rst_stage_q;
        case (state_q)
            ST_POR: begin
                rst_stage_d = '1;
                if (force_rst) begin
                    state_d = ST_HOLD;
                end else if (por_cnt_q == POR_W'(POR_CYCLES - 1)) begin
                    rst_stage_d[0] = 1'b0;
                    gap_cnt_d      = '0;
                    idx_d          = IDX_W'(1);
                    state_d        = (NUM_RST == 1) ? ST_RUN : ST_STAGE;
                end else begin
                    por_cnt_d = por_cnt_q + POR_W'(1);
                end
            end
            ST_STAGE: begin
                if (force_rst) begin
                    rst_stage_d = '1;
                    state_d     = ST_HOLD;
                end else if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
                    rst_stage_d[idx_q] = 1'b0;
                    gap_cnt_d          = '0;
                    if (idx_q == IDX_W'(NUM_RST - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_RUN: begin
                rst_stage_d = '0;
                if (force_rst) begin
                    rst_stage_d = '1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                rst_stage_d = '1;
                if (!force_rst) begin
                    por_cnt_d = '0;
                    state_d   = ST_POR;
                end
            end
            default: begin
                rst_stage_d = '1;
                por_cnt_d   = '0;
                state_d     = ST_POR;
            end
        endcase
    end

    logic [STR_W-1:0]   str_cnt_q [NUM_LED];
    logic [STR_W-1:0]   str_cnt_d [NUM_LED];
    logic [NUM_LED-1:0] led_raw;
    logic [NUM_LED-1:0] led_q, led_d;

    // Stretch counters run regardless of mode so ACT reflects recent history.
    always_comb begin
        led_raw = '0;
        led_d   = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            if (led_act[i]) begin
                str_cnt_d[i] = STR_W'(STRETCH_CYCLES);
            end else if (str_cnt_q[i] != '0) begin
                str_cnt_d[i] = str_cnt_q[i] - STR_W'(1);
            end else begin
                str_cnt_d[i] = '0;
            end
            case (led_mode_t'(led_mode[2*i +: 2]))
                LED_OFF:   led_raw[i] = 1'b0;
                LED_ON:    led_raw[i] = 1'b1;
                LED_BLINK: led_raw[i] = tick_q[BLINK_BIT];
                LED_ACT:   led_raw[i] = (str_cnt_q[i] != '0);
                default:   led_raw[i] = 1'b0;
            endcase
            led_d[i] = led_raw[i] ^ led_inv[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q      <= '0;
            state_q     <= ST_POR;
            por_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            rst_stage_q <= '1;
            led_q       <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                str_cnt_q[i] <= '0;
            end
        end else begin
            tick_q      <= tick_q + 64'd1;
            state_q     <= state_d;
            por_cnt_q   <= por_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            idx_q       <= idx_d;
            rst_stage_q <= rst_stage_d;
            led_q       <= led_d;
            for (int i = 0; i < NUM_LED; i++) begin
                str_cnt_q[i] <= str_cnt_d[i];
            end
        end
    end

    assign tickcount64 = tick_q;
    assign rst_stage   = rst_stage_q;
    assign led         = led_q;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Directed bench for pcileech_sysctl with shortened timing parameters.
module tb_pcileech_sysctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  btn_raw = '0;
    logic [1:0]  btn_db;
    logic [63:0] tickcount64;
    logic [2:0]  rst_stage;
    logic [5:0]  led_mode = '0;
    logic [2:0]  led_act = '0;
    logic [2:0]  led_inv = '0;
    logic [2:0]  led;

    int tests = 0;
    int fails = 0;
    int edges = 0;

    pcileech_sysctl #(
        .NUM_BTN(2), .NUM_LED(3), .NUM_RST(3),
        .POR_CYCLES(64), .STAGE_GAP(16), .DEBOUNCE_CYCLES(8),
        .BTN_RST_MASK(2'b10), .BLINK_BIT(3), .STRETCH_CYCLES(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_db(btn_db),
        .tickcount64(tickcount64), .rst_stage(rst_stage),
        .led_mode(led_mode), .led_act(led_act), .led_inv(led_inv), .led(led)
    );

    always #5 clk = ~clk;

    // Rising edges since the last rst_n deassertion; equals the expected tick count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic watch_release(input int limit, output int f0, output int f1,
                                 output int f2, output logic [63:0] t_last);
        f0 = -1; f1 = -1; f2 = -1; t_last = '0;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (f0 < 0 && !rst_stage[0]) f0 = n;
            if (f1 < 0 && !rst_stage[1]) f1 = n;
            if (f2 < 0 && !rst_stage[2]) begin
                f2 = n;
                t_last = tickcount64;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (tickcount64 !== 64'd0) begin fails++; $display("FAIL reset_tick: got %0d expected 0", tickcount64); end
        tests++; if (rst_stage !== 3'b111) begin fails++; $display("FAIL reset_stage: got %b expected 111", rst_stage); end
        tests++; if (btn_db !== 2'b00) begin fails++; $display("FAIL reset_btn_db: got %b expected 00", btn_db); end
        tests++; if (led !== 3'b000) begin fails++; $display("FAIL reset_led: got %b expected 000", led); end
    endtask

    task automatic test_power_up();
        int f0, f1, f2;
        logic [63:0] t;
        @(negedge clk);
        rst_n = 1'b1;
        watch_release(110, f0, f1, f2, t);
        tests++; if (f0 !== 64) begin fails++; $display("FAIL por_stage0: got edge %0d expected 64", f0); end
        tests++; if (f1 !== 80) begin fails++; $display("FAIL por_stage1: got edge %0d expected 80", f1); end
        tests++; if (f2 !== 96) begin fails++; $display("FAIL por_stage2: got edge %0d expected 96", f2); end
        tests++; if (t !== 64'd96) begin fails++; $display("FAIL por_tick: got %0d expected 96", t); end
        tests++; if (rst_stage !== 3'b000) begin fails++; $display("FAIL por_run: got %b expected 000", rst_stage); end
    endtask

    task automatic test_debounce();
        int n;
        logic seen;
        @(negedge clk);
        btn_raw[0] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        btn_raw[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (btn_db[0]) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL db_glitch: got btn_db high %b expected 0", seen); end

        @(negedge clk);
        btn_raw[0] = 1'b1;
        n = 0;
        while (!btn_db[0] && n < 40) begin
            tick();
            n++;
        end
        tests++; if (n !== 10) begin fails++; $display("FAIL db_latency: got %0d cycles expected 10", n); end
        repeat (10) tick();
        tests++; if (btn_db[0] !== 1'b1) begin fails++; $display("FAIL db_held: got %b expected 1", btn_db[0]); end
        tests++; if (rst_stage !== 3'b000) begin fails++; $display("FAIL db_unmasked_stage: got %b expected 000", rst_stage); end
        @(negedge clk);
        btn_raw[0] = 1'b0;
        repeat (15) tick();
        tests++; if (btn_db[0] !== 1'b0) begin fails++; $display("FAIL db_release: got %b expected 0", btn_db[0]); end
    endtask

    task automatic test_forced_reset();
        int n, f0, f1, f2;
        logic [63:0] t;
        @(negedge clk);
        btn_raw[1] = 1'b1;
        n = 0;
        while (!btn_db[1] && n < 40) begin
            tick();
            n++;
        end
        tests++; if (n !== 10) begin fails++; $display("FAIL force_db_latency: got %0d expected 10", n); end
        tests++; if (rst_stage !== 3'b000) begin fails++; $display("FAIL force_same_edge: got %b expected 000", rst_stage); end
        tick();
        tests++; if (rst_stage !== 3'b111) begin fails++; $display("FAIL force_assert: got %b expected 111", rst_stage); end
        repeat (20) tick();
        tests++; if (rst_stage !== 3'b111) begin fails++; $display("FAIL force_hold: got %b expected 111", rst_stage); end
        @(negedge clk);
        btn_raw[1] = 1'b0;
        n = 0;
        while (btn_db[1] && n < 40) begin
            tick();
            n++;
        end
        tests++; if (n !== 10) begin fails++; $display("FAIL force_db_fall: got %0d expected 10", n); end
        // One extra edge for HOLD->POR, then the same 64/16/16 spacing as power-up.
        watch_release(110, f0, f1, f2, t);
        tests++; if (f0 !== 65) begin fails++; $display("FAIL force_rel0: got edge %0d expected 65", f0); end
        tests++; if (f1 !== 81) begin fails++; $display("FAIL force_rel1: got edge %0d expected 81", f1); end
        tests++; if (f2 !== 97) begin fails++; $display("FAIL force_rel2: got edge %0d expected 97", f2); end
        tests++; if (tickcount64 !== 64'(edges)) begin fails++; $display("FAIL force_tick_kept: got %0d expected %0d", tickcount64, edges); end
    endtask

    task automatic test_led();
        logic        exp_act;
        logic        exp_blink;
        logic [63:0] prev;
        logic [1:0]  modes [4];
        logic        invs  [4];
        logic        exps  [4];
        @(negedge clk);
        led_mode = {2'd2, 2'd3, 2'd3};
        led_inv  = 3'b010;
        repeat (2) tick();
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            led_act = (n == 0 || n == 5) ? 3'b011 : 3'b000;
            tick();
            exp_act   = (n >= 1 && n <= 15);
            prev      = 64'(edges - 1);
            exp_blink = prev[3];
            tests++;
            if (led !== {exp_blink, ~exp_act, exp_act}) begin
                fails++;
                $display("FAIL led_act_blink n=%0d: got %b expected %b", n, led, {exp_blink, ~exp_act, exp_act});
            end
        end
        @(negedge clk);
        led_act = '0;
        modes = '{2'd1, 2'd0, 2'd0, 2'd1};
        invs  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exps  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            led_mode[5:4] = modes[i];
            led_inv[2]    = invs[i];
            tick();
            tests++;
            if (led[2] !== exps[i]) begin
                fails++;
                $display("FAIL led_static mode=%0d inv=%b: got %b expected %b", modes[i], invs[i], led[2], exps[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int f0, f1, f2;
        logic [63:0] t;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) tick();
        tests++; if (rst_stage !== 3'b110) begin fails++; $display("FAIL mid_stage: got %b expected 110", rst_stage); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (rst_stage !== 3'b111) begin fails++; $display("FAIL async_stage: got %b expected 111", rst_stage); end
        tests++; if (tickcount64 !== 64'd0) begin fails++; $display("FAIL async_tick: got %0d expected 0", tickcount64); end
        tests++; if (led !== 3'b000) begin fails++; $display("FAIL async_led: got %b expected 000", led); end
        @(negedge clk);
        rst_n = 1'b1;
        watch_release(110, f0, f1, f2, t);
        tests++; if (f0 !== 64) begin fails++; $display("FAIL restart_stage0: got edge %0d expected 64", f0); end
        tests++; if (f2 !== 96) begin fails++; $display("FAIL restart_stage2: got edge %0d expected 96", f2); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_debounce();
        test_forced_reset();
        test_led();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
